if_fetch_seq: RTL and testbench

//   Fetch-side producer for the 16-entry instruction fetch buffer.
//   - Generates sequential 8-byte-aligned fetch PCs and issues I-cache requests.
//   - Collects in-order 64-bit I-cache responses (two instructions each).
//   - Enqueues them into the fetch buffer via a valid/ready push interface.
//   - Handles redirects by discarding every stale in-flight response.

---
 rtl/if_fetch_seq.sv | 106 ++++++++++
 tb/tb_if_fetch_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_seq.sv
// if_fetch_seq: sequential fetch PC generator and I-cache response
// collector feeding the instruction fetch buffer.
module if_fetch_seq #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        enq_valid,
  output logic [63:0] enq_data,
  input  logic        enq_ready,
  output logic        busy
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam logic [63:0] PC0 = {RESET_PC[63:3], 3'b0};
  localparam logic [CW:0] LIMIT = (CW + 1)'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [63:0]   pc;
  logic [CW-1:0] pend;
  logic [CW-1:0] pend_nxt;
  logic [CW-1:0] drop;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [63:0]   mem [MAX_OUTSTANDING];
  logic [CW:0]   used;
  logic          fire;
  logic          push;
  logic          pop;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[2:0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fetch_en) state_nxt = RUN;
      RUN:     if (!fetch_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // queued packets still hold a credit until the fetch buffer takes them
  assign used      = {1'b0, pend} + {1'b0, cnt};
  assign req_valid = (state == RUN) && !redirect_valid && (used < LIMIT);
  assign req_addr  = pc;
  assign fire      = req_valid && req_ready;
  assign pend_nxt  = pend + CW'(fire) - CW'(resp_valid);

  assign push = resp_valid && !redirect_valid && (drop == '0);
  assign pop  = enq_valid && enq_ready && !redirect_valid;

  assign enq_valid = (cnt != '0);
  assign enq_data  = enq_valid ? mem[rd_ptr] : 64'h0;
  assign busy      = (pend != '0) || (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= PC0;
      pend   <= '0;
      drop   <= '0;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (redirect_valid) begin
        pc     <= {redirect_pc[63:3], 3'b0};
        drop   <= pend_nxt;
        cnt    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (fire) pc <= pc + 64'd8;
        if (resp_valid && (drop != '0)) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= resp_data;
  end

endmodule

// File: tb/tb_if_fetch_seq.sv
// tb_if_fetch_seq: directed scenarios for the fetch sequencer.
// Expected addresses and packets are hand-derived per scenario.
module tb_if_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        enq_valid;
  logic [63:0] enq_data;
  logic        enq_ready;
  logic        busy;

  int          tot = 0;
  int          pass_cnt = 0;
  int          fire_cnt = 0;
  bit          auto_resp = 0;
  logic [63:0] fq[$];
  logic [63:0] eq[$];

  always #5 clk = ~clk;

  if_fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .enq_valid      (enq_valid),
    .enq_data       (enq_data),
    .enq_ready      (enq_ready),
    .busy           (busy)
  );

  function automatic logic [63:0] dat(input logic [63:0] a);
    return {a[31:0], ~a[31:0]};
  endfunction

  // one clock: record fires/responses, then optionally answer the oldest fire
  task automatic cyc();
    logic [63:0] a;
    #2;
    if (req_valid && req_ready) begin
      fq.push_back(req_addr);
      fire_cnt++;
    end
    if (resp_valid && !redirect_valid) eq.push_back(resp_data);
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    if (auto_resp && fq.size() > 0) begin
      a = fq.pop_front();
      resp_valid = 1'b1;
      resp_data = dat(a);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_data = 64'h0;
    enq_ready = 1'b0;
    auto_resp = 0;
    fire_cnt = 0;
    fq.delete();
    eq.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    resp_valid = 1'b0;
    resp_data = 64'h0;
    @(posedge clk);
    #3;
    tot++;
    if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", req_valid);
    else pass_cnt++;
    tot++;
    if (req_addr !== 64'h0) $display("FAIL rst_req_addr got %h want 0", req_addr);
    else pass_cnt++;
    tot++;
    if (enq_valid !== 1'b0) $display("FAIL rst_enq_valid got %b want 0", enq_valid);
    else pass_cnt++;
    tot++;
    if (enq_data !== 64'h0) $display("FAIL rst_enq_data got %h want 0", enq_data);
    else pass_cnt++;
    tot++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_seq();
    logic [63:0] exp_pc;
    exp_pc = 64'h0;
    do_reset();
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b1;
    auto_resp = 1;
    #2;
    tot++;
    if (req_valid !== 1'b0) $display("FAIL seq_idle got %b want 0", req_valid);
    else pass_cnt++;
    cyc();
    for (int i = 0; i < 6; i++) begin
      #2;
      tot++;
      if (req_valid !== 1'b1 || req_addr !== exp_pc)
        $display("FAIL seq_addr got %b/%h want 1/%h", req_valid, req_addr, exp_pc);
      else pass_cnt++;
      if (eq.size() > 0) begin
        tot++;
        if (enq_valid !== 1'b1 || enq_data !== eq[0])
          $display("FAIL seq_enq got %b/%h want 1/%h", enq_valid, enq_data, eq[0]);
        else pass_cnt++;
        void'(eq.pop_front());
      end
      exp_pc += 64'd8;
      cyc();
    end
    fetch_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (eq.size() > 0) begin
        tot++;
        if (enq_valid !== 1'b1 || enq_data !== eq[0])
          $display("FAIL seq_drain got %b/%h want 1/%h", enq_valid, enq_data, eq[0]);
        else pass_cnt++;
        void'(eq.pop_front());
      end
      cyc();
    end
    #2;
    tot++;
    if (busy !== 1'b0 || enq_valid !== 1'b0)
      $display("FAIL seq_idle_end got busy=%b enq=%b want 0/0", busy, enq_valid);
    else pass_cnt++;
  endtask

  task automatic test_credit();
    do_reset();
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b0;
    auto_resp = 1;
    repeat (9) cyc();
    #2;
    tot++;
    if (req_valid !== 1'b0) $display("FAIL credit_stall got %b want 0", req_valid);
    else pass_cnt++;
    tot++;
    if (fire_cnt !== 4) $display("FAIL credit_fires got %0d want 4", fire_cnt);
    else pass_cnt++;
    tot++;
    if (enq_valid !== 1'b1 || enq_data !== dat(64'h0) || busy !== 1'b1)
      $display("FAIL credit_hold got %b/%h/%b want 1/%h/1",
               enq_valid, enq_data, busy, dat(64'h0));
    else pass_cnt++;
    enq_ready = 1'b1;
    void'(eq.pop_front());
    cyc();
    #2;
    tot++;
    if (req_valid !== 1'b1 || req_addr !== 64'd32)
      $display("FAIL credit_resume got %b/%h want 1/20", req_valid, req_addr);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) #2;
      tot++;
      if (enq_valid !== 1'b1 || enq_data !== dat(64'd8 * (k + 1)))
        $display("FAIL credit_order got %b/%h want 1/%h",
                 enq_valid, enq_data, dat(64'd8 * (k + 1)));
      else pass_cnt++;
      cyc();
    end
    fetch_en = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic test_redirect_drop();
    bit ok;
    do_reset();
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b1;
    repeat (4) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h1003;
    #2;
    tot++;
    if (req_valid !== 1'b0) $display("FAIL redir_block got %b want 0", req_valid);
    else pass_cnt++;
    cyc();
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    auto_resp = 1;
    #2;
    tot++;
    if (req_valid !== 1'b1 || req_addr !== 64'h1000)
      $display("FAIL redir_addr got %b/%h want 1/1000", req_valid, req_addr);
    else pass_cnt++;
    cyc();
    ok = 1;
    repeat (4) begin
      #2;
      if (enq_valid !== 1'b0) ok = 0;
      cyc();
    end
    tot++;
    if (!ok) $display("FAIL redir_discard got stale enq want none");
    else pass_cnt++;
    #2;
    tot++;
    if (enq_valid !== 1'b1 || enq_data !== dat(64'h1000))
      $display("FAIL redir_first got %b/%h want 1/%h",
               enq_valid, enq_data, dat(64'h1000));
    else pass_cnt++;
    cyc();
    #2;
    tot++;
    if (busy !== 1'b0) $display("FAIL redir_busy got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_redirect_resp();
    do_reset();
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b0;
    repeat (5) cyc();
    resp_valid = 1'b1;
    resp_data = dat(64'd0);
    cyc();
    resp_valid = 1'b1;
    resp_data = dat(64'd8);
    cyc();
    resp_valid = 1'b1;
    resp_data = dat(64'd16);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    fetch_en = 1'b0;
    #2;
    tot++;
    if (enq_valid !== 1'b1 || enq_data !== dat(64'd0))
      $display("FAIL flush_pre got %b/%h want 1/%h", enq_valid, enq_data, dat(64'd0));
    else pass_cnt++;
    cyc();
    redirect_valid = 1'b0;
    resp_valid = 1'b1;
    resp_data = dat(64'd24);
    #2;
    tot++;
    if (enq_valid !== 1'b0) $display("FAIL flush_q got %b want 0", enq_valid);
    else pass_cnt++;
    tot++;
    if (busy !== 1'b1) $display("FAIL flush_busy got %b want 1", busy);
    else pass_cnt++;
    cyc();
    #2;
    tot++;
    if (enq_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_drop got enq=%b busy=%b want 0/0", enq_valid, busy);
    else pass_cnt++;
    fetch_en = 1'b1;
    enq_ready = 1'b1;
    cyc();
    fetch_en = 1'b0;
    #2;
    tot++;
    if (req_valid !== 1'b1 || req_addr !== 64'h2000)
      $display("FAIL flush_newpc got %b/%h want 1/2000", req_valid, req_addr);
    else pass_cnt++;
    cyc();
    resp_valid = 1'b1;
    resp_data = dat(64'h2000);
    cyc();
    #2;
    tot++;
    if (enq_valid !== 1'b1 || enq_data !== dat(64'h2000))
      $display("FAIL flush_newenq got %b/%h want 1/%h",
               enq_valid, enq_data, dat(64'h2000));
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    auto_resp = 1;
    #2;
    tot++;
    if (req_valid !== 1'b1 || req_addr !== 64'hFFFF_FFFF_FFFF_FFF8)
      $display("FAIL wrap_top got %b/%h want 1/fffffffffffffff8", req_valid, req_addr);
    else pass_cnt++;
    cyc();
    fetch_en = 1'b0;
    #2;
    tot++;
    if (req_valid !== 1'b1 || req_addr !== 64'h0)
      $display("FAIL wrap_zero got %b/%h want 1/0", req_valid, req_addr);
    else pass_cnt++;
    cyc();
    #2;
    tot++;
    if (enq_valid !== 1'b1 || enq_data !== dat(64'hFFFF_FFFF_FFFF_FFF8))
      $display("FAIL wrap_enq got %b/%h want 1/%h",
               enq_valid, enq_data, dat(64'hFFFF_FFFF_FFFF_FFF8));
    else pass_cnt++;
    cyc();
    #2;
    tot++;
    if (enq_valid !== 1'b1 || enq_data !== dat(64'h0))
      $display("FAIL wrap_enq0 got %b/%h want 1/%h", enq_valid, enq_data, dat(64'h0));
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1;
    req_ready = 1'b1;
    enq_ready = 1'b0;
    repeat (3) cyc();
    fetch_en = 1'b0;
    cyc();
    fetch_en = 1'b1;
    resp_valid = 1'b1;
    resp_data = dat(64'd0);
    cyc();
    #2;
    tot++;
    if (req_valid !== 1'b1 || enq_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL arst_pre got %b/%b/%b want 1/1/1", req_valid, enq_valid, busy);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    tot++;
    if (req_valid !== 1'b0) $display("FAIL arst_req got %b want 0", req_valid);
    else pass_cnt++;
    tot++;
    if (enq_valid !== 1'b0) $display("FAIL arst_enq got %b want 0", enq_valid);
    else pass_cnt++;
    tot++;
    if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy);
    else pass_cnt++;
    tot++;
    if (req_addr !== 64'h0) $display("FAIL arst_addr got %h want 0", req_addr);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_credit();
    test_redirect_drop();
    test_redirect_resp();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule
